rv32imf_instr_obi_interface: RTL

Instruction-side OBI bus adapter sitting directly downstream of the prefetch controller. Accepts fetch transactions (valid/ready/address), issues them as OBI read requests, holds address and request stable while the bus withholds grant, and returns read responses upstream as single-cycle pulses. It also bounds outstanding requests and flags unsolicited responses.

---
 rtl/rv32imf_instr_obi_interface_if.sv | 32 +++
 rtl/rv32imf_instr_obi_interface.sv | 112 +++++++++++
 2 files changed

// File: rtl/rv32imf_instr_obi_interface_if.sv
// Fetch-side and OBI-side signals of the instruction bus adapter.
// The master modport is the adapter's view; slave is the surrounding system.
interface rv32imf_instr_obi_interface_if;
  logic        trans_valid_i;
  logic        trans_ready_o;
  logic [31:0] trans_addr_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  modport master (
    input  trans_valid_i, trans_addr_i,
    output trans_ready_o,
    output resp_valid_o, resp_rdata_o, resp_err_o,
    output obi_req_o, obi_addr_o,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );

  modport slave (
    output trans_valid_i, trans_addr_i,
    input  trans_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_err_o,
    input  obi_req_o, obi_addr_o,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );
endinterface

// File: rtl/rv32imf_instr_obi_interface.sv
// Instruction-side OBI adapter: issues fetches as OBI reads, holds stalled
// requests stable, bounds outstanding reads and flags unsolicited responses.
module rv32imf_instr_obi_interface #(
  parameter bit          TRANS_STABLE    = 1'b0,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  rv32imf_instr_obi_interface_if.master   bus,
  output logic                            proto_err_o
);

  typedef enum logic {
    ST_TRANSPARENT,
    ST_REGISTERED
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             proto_err_q, proto_err_d;

  logic        room;
  logic [31:0] addr_aligned;
  logic        req;
  logic [31:0] req_addr;
  logic        ready;
  logic        inc, dec;

  assign room         = (outst_q < MAX_CNT);
  assign addr_aligned = bus.trans_addr_i & ~32'h0000_0003;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req     = 1'b0;
    req_addr = addr_aligned;
    ready   = 1'b0;

    if (TRANS_STABLE) begin
      req      = bus.trans_valid_i && room;
      req_addr = addr_aligned;
      ready    = bus.obi_gnt_i && room;
      state_d  = ST_TRANSPARENT;
    end else begin
      unique case (state_q)
        ST_TRANSPARENT: begin
          req      = bus.trans_valid_i && room;
          req_addr = addr_aligned;
          ready    = room;
          if (req && !bus.obi_gnt_i) begin
            addr_d  = addr_aligned;
            state_d = ST_REGISTERED;
          end
        end
        ST_REGISTERED: begin
          // OBI forbids retracting a request, so hold it regardless of upstream and room.
          req      = 1'b1;
          req_addr = addr_q;
          ready    = 1'b0;
          if (bus.obi_gnt_i) begin
            state_d = ST_TRANSPARENT;
          end
        end
        default: begin
          state_d = ST_TRANSPARENT;
        end
      endcase
    end
  end

  // An rvalid with nothing outstanding is a protocol error and must not underflow.
  always_comb begin
    inc         = req && bus.obi_gnt_i;
    dec         = bus.obi_rvalid_i && (outst_q != '0);
    outst_d     = outst_q;
    proto_err_d = proto_err_q | (bus.obi_rvalid_i && (outst_q == '0));
    unique case ({inc, dec})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_TRANSPARENT;
      addr_q      <= '0;
      outst_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      outst_q     <= outst_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.obi_req_o     = req;
  assign bus.obi_addr_o    = req_addr;
  assign bus.trans_ready_o = ready;

  assign bus.resp_valid_o  = bus.obi_rvalid_i;
  assign bus.resp_rdata_o  = bus.obi_rdata_i;
  assign bus.resp_err_o    = bus.obi_err_i;

  assign proto_err_o = proto_err_q;

endmodule
